s2p_frame_ctrl: RTL and testbench

//  Sequencer for the s2p deserializer: on a start pulse it hunts the serial line for a

---
 rtl/s2p_frame_ctrl_if.sv | 26 ++
 rtl/s2p_frame_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_s2p_frame_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s2p_frame_ctrl_if.sv
// Signal bundle shared by s2p_frame_ctrl, its s2p deserializer and the frame consumer.
// The controller side is "master"; the s2p/consumer side is "slave".
interface s2p_frame_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
);
    logic             s2p_en;
    logic             s2p_valid;
    logic [WIDTH-1:0] s2p_po;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic [IDX_W-1:0] word_idx;
    logic             frame_sof;
    logic             frame_eof;
    logic             done;

    modport master (
        output s2p_en, word_out, word_valid, word_idx, frame_sof, frame_eof, done,
        input  s2p_valid, s2p_po
    );

    modport slave (
        input  s2p_en, word_out, word_valid, word_idx, frame_sof, frame_eof, done,
        output s2p_valid, s2p_po
    );
endinterface

// File: rtl/s2p_frame_ctrl.sv
// Frame sequencer for the s2p deserializer: hunts the serial line for SYNC, then owns
// s2p dat_en for FRAME_WORDS words and forwards them with index and frame delimiters.
module s2p_frame_ctrl #(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] SYNC         = 4'b1011,
    parameter int               FRAME_WORDS  = 3,
    parameter int               GAP_CYCLES   = 4,
    parameter int               HUNT_TIMEOUT = 64,
    parameter bit               CONTINUOUS   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             si,
    s2p_frame_ctrl_if.master bus,
    output logic             err_timeout,
    output logic             busy
);
    localparam int IDX_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int FILL_W = $clog2(WIDTH);
    localparam int TCNT_W = (HUNT_TIMEOUT > 1) ? $clog2(HUNT_TIMEOUT) : 1;
    localparam int WD_W   = $clog2(WIDTH + 2);
    localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(HUNT_TIMEOUT - 1);
    localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);
    localparam logic [IDX_W-1:0]  WCNT_LAST = IDX_W'(FRAME_WORDS - 1);
    localparam logic [IDX_W-1:0]  WCNT_ONE  = IDX_W'(1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(WIDTH + 1);
    localparam logic [WD_W-1:0]   WD_ONE    = WD_W'(1);
    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GAP_CYCLES - 1);
    localparam logic [GCNT_W-1:0] GCNT_ONE  = GCNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        LOAD = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-2:0]   sh_r, sh_s;
    logic [FILL_W-1:0]  fill_r, fill_s;
    logic [TCNT_W-1:0]  tcnt_r, tcnt_s;
    logic [IDX_W-1:0]   wcnt_r, wcnt_s;
    logic [WD_W-1:0]    wd_r, wd_s;
    logic [GCNT_W-1:0]  gcnt_r, gcnt_s;
    logic               s2p_en_r, s2p_en_s;
    logic [WIDTH-1:0]   word_out_r, word_out_s;
    logic               word_valid_r, word_valid_s;
    logic [IDX_W-1:0]   word_idx_r, word_idx_s;
    logic               sof_r, sof_s;
    logic               eof_r, eof_s;
    logic               done_r, done_s;
    logic               err_r, err_s;
    logic               busy_r, busy_s;
    logic [WIDTH-1:0]   hunt_word_s;

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        state_s      = state_r;
        sh_s         = sh_r;
        fill_s       = fill_r;
        tcnt_s       = tcnt_r;
        wcnt_s       = wcnt_r;
        wd_s         = wd_r;
        gcnt_s       = gcnt_r;
        s2p_en_s     = s2p_en_r;
        word_out_s   = word_out_r;
        word_valid_s = 1'b0;
        word_idx_s   = word_idx_r;
        sof_s        = 1'b0;
        eof_s        = 1'b0;
        done_s       = 1'b0;
        err_s        = 1'b0;
        hunt_word_s  = {sh_r, si};

        if (abort) begin
            // abort beats everything, including a same-cycle start or s2p_valid
            state_s  = IDLE;
            s2p_en_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_s = HUNT;
                        sh_s    = '0;
                        fill_s  = '0;
                        tcnt_s  = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                HUNT: begin
                    sh_s = hunt_word_s[WIDTH-2:0];
                    if (fill_r != FILL_LAST) begin
                        fill_s = fill_r + FILL_ONE;
                    end else begin
                        fill_s = fill_r;
                    end
                    // fill counts bits already held in sh, so the window is only valid once full
                    if ((fill_r == FILL_LAST) && (hunt_word_s == SYNC)) begin
                        state_s  = LOAD;
                        s2p_en_s = 1'b1;
                        wcnt_s   = '0;
                        wd_s     = '0;
                    end else if (tcnt_r == TCNT_LAST) begin
                        state_s = IDLE;
                        err_s   = 1'b1;
                    end else begin
                        tcnt_s = tcnt_r + TCNT_ONE;
                    end
                end
                LOAD: begin
                    if (bus.s2p_valid) begin
                        word_out_s   = bus.s2p_po;
                        word_valid_s = 1'b1;
                        word_idx_s   = wcnt_r;
                        sof_s        = (wcnt_r == '0);
                        eof_s        = (wcnt_r == WCNT_LAST);
                        wd_s         = '0;
                        if (wcnt_r == WCNT_LAST) begin
                            done_s   = 1'b1;
                            s2p_en_s = 1'b0;
                            gcnt_s   = '0;
                            state_s  = GAP;
                        end else begin
                            wcnt_s = wcnt_r + WCNT_ONE;
                        end
                    end else if (wd_r == WD_LAST) begin
                        err_s    = 1'b1;
                        s2p_en_s = 1'b0;
                        state_s  = IDLE;
                    end else begin
                        wd_s = wd_r + WD_ONE;
                    end
                end
                GAP: begin
                    if (gcnt_r == GCNT_LAST) begin
                        if (CONTINUOUS) begin
                            state_s = HUNT;
                            sh_s    = '0;
                            fill_s  = '0;
                            tcnt_s  = '0;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        gcnt_s = gcnt_r + GCNT_ONE;
                    end
                end
                default: begin
                    state_s  = IDLE;
                    s2p_en_s = 1'b0;
                end
            endcase
        end

        busy_s = (state_s != IDLE);
    end

    // State, counters and registered outputs; rst clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            sh_r         <= '0;
            fill_r       <= '0;
            tcnt_r       <= '0;
            wcnt_r       <= '0;
            wd_r         <= '0;
            gcnt_r       <= '0;
            s2p_en_r     <= 1'b0;
            word_out_r   <= '0;
            word_valid_r <= 1'b0;
            word_idx_r   <= '0;
            sof_r        <= 1'b0;
            eof_r        <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            sh_r         <= sh_s;
            fill_r       <= fill_s;
            tcnt_r       <= tcnt_s;
            wcnt_r       <= wcnt_s;
            wd_r         <= wd_s;
            gcnt_r       <= gcnt_s;
            s2p_en_r     <= s2p_en_s;
            word_out_r   <= word_out_s;
            word_valid_r <= word_valid_s;
            word_idx_r   <= word_idx_s;
            sof_r        <= sof_s;
            eof_r        <= eof_s;
            done_r       <= done_s;
            err_r        <= err_s;
            busy_r       <= busy_s;
        end
    end

    assign bus.s2p_en     = s2p_en_r;
    assign bus.word_out   = word_out_r;
    assign bus.word_valid = word_valid_r;
    assign bus.word_idx   = word_idx_r;
    assign bus.frame_sof  = sof_r;
    assign bus.frame_eof  = eof_r;
    assign bus.done       = done_r;
    assign err_timeout    = err_r;
    assign busy           = busy_r;
endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Bench for s2p_frame_ctrl: table vectors, directed corner sequences and random streams
// checked per cycle against a frame-level reference model.
module tb_s2p_frame_ctrl;
    localparam int         W     = 4;
    localparam int         FW    = 3;
    localparam int         GAP   = 4;
    localparam int         HT    = 64;
    localparam int         NCYC  = 96;
    localparam logic [3:0] SYNC  = 4'b1011;
    localparam int         NONE  = -100;

    typedef struct packed {
        logic       en;
        logic       wv;
        logic [3:0] wo;
        logic [1:0] idx;
        logic       sof;
        logic       eof;
        logic       done;
        logic       err;
        logic       busy;
    } obs_t;

    typedef struct {
        logic [15:0] pre;
        int          plen;
        logic [11:0] data;
        int          exp_j;
    } vec_t;

    logic clk, rst, start, start1, abort, si, mute;
    logic err0, busy0, err1, busy1;
    logic [1:0] cnt0, cnt1;
    logic [3:0] sh0, sh1, po0, po1;
    logic       val0, val1;

    int checks, failures, ptr;
    logic [NCYC-1:0] stim;
    obs_t obs0 [NCYC];
    obs_t exp0 [NCYC];
    obs_t obs1 [NCYC];

    s2p_frame_ctrl_if #(.WIDTH(4), .IDX_W(2)) bus0 ();
    s2p_frame_ctrl_if #(.WIDTH(4), .IDX_W(2)) bus1 ();

    s2p_frame_ctrl #(.WIDTH(4), .SYNC(4'b1011), .FRAME_WORDS(3), .GAP_CYCLES(4),
                     .HUNT_TIMEOUT(64), .CONTINUOUS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .si(si),
        .bus(bus0.master), .err_timeout(err0), .busy(busy0));

    s2p_frame_ctrl #(.WIDTH(4), .SYNC(4'b1011), .FRAME_WORDS(3), .GAP_CYCLES(4),
                     .HUNT_TIMEOUT(64), .CONTINUOUS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort), .si(si),
        .bus(bus1.master), .err_timeout(err1), .busy(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // s2p models: MSB-first shift, dat_valid one cycle after the WIDTH-th enabled bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= 2'd0; sh0 <= 4'h0; val0 <= 1'b0; po0 <= 4'h0;
        end else if (bus0.s2p_en) begin
            sh0 <= {sh0[2:0], si};
            if (cnt0 == 2'd3) begin
                val0 <= !mute; po0 <= {sh0[2:0], si}; cnt0 <= 2'd0;
            end else begin
                val0 <= 1'b0; cnt0 <= cnt0 + 2'd1;
            end
        end else begin
            cnt0 <= 2'd0; val0 <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt1 <= 2'd0; sh1 <= 4'h0; val1 <= 1'b0; po1 <= 4'h0;
        end else if (bus1.s2p_en) begin
            sh1 <= {sh1[2:0], si};
            if (cnt1 == 2'd3) begin
                val1 <= 1'b1; po1 <= {sh1[2:0], si}; cnt1 <= 2'd0;
            end else begin
                val1 <= 1'b0; cnt1 <= cnt1 + 2'd1;
            end
        end else begin
            cnt1 <= 2'd0; val1 <= 1'b0;
        end
    end

    assign bus0.s2p_valid = val0;
    assign bus0.s2p_po    = po0;
    assign bus1.s2p_valid = val1;
    assign bus1.s2p_po    = po1;

    task automatic check(input string nm, input int t, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, t, act, expv);
        end
    endtask

    function automatic obs_t mask(input obs_t o);
        obs_t m;
        m = o;
        if (!m.wv) begin
            m.wo  = 4'h0;
            m.idx = 2'd0;
        end
        return m;
    endfunction

    task automatic push(input logic [15:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            stim[ptr] = v[k];
            ptr++;
        end
    endtask

    // Reference: locate the first SYNC window, then place every output event by arithmetic.
    task automatic build_exp(input logic [NCYC-1:0] bits, input int ab);
        int j;
        logic [3:0] win;
        logic [3:0] wrd;
        j = -1;
        for (int t = 0; t < NCYC; t++) exp0[t] = '0;
        for (int t = W - 1; t < HT; t++) begin
            if (j < 0) begin
                for (int k = 0; k < W; k++) win[k] = bits[t - k];
                if (win == SYNC) j = t;
            end
        end
        if (j < 0) begin
            for (int t = 0; t < HT; t++) exp0[t].busy = 1'b1;
            exp0[HT].err = 1'b1;
        end else begin
            for (int t = 0; t <= j + 1 + W * FW + GAP; t++) exp0[t].busy = 1'b1;
            for (int t = j + 1; t <= j + 1 + W * FW; t++) exp0[t].en = 1'b1;
            for (int w = 0; w < FW; w++) begin
                for (int k = 0; k < W; k++) wrd[W - 1 - k] = bits[j + 1 + W * w + k];
                exp0[j + 2 + W * (w + 1)].wv   = 1'b1;
                exp0[j + 2 + W * (w + 1)].wo   = wrd;
                exp0[j + 2 + W * (w + 1)].idx  = 2'(w);
                exp0[j + 2 + W * (w + 1)].sof  = (w == 0);
                exp0[j + 2 + W * (w + 1)].eof  = (w == FW - 1);
                exp0[j + 2 + W * (w + 1)].done = (w == FW - 1);
            end
        end
        if (ab >= -1) begin
            for (int t = ab + 1; t < NCYC; t++) exp0[t] = '0;
        end
    endtask

    // One capture on dut0: start in cycle -1, then bits[t] on si in HUNT-relative cycle t.
    task automatic run0(input logic [NCYC-1:0] bits, input int ab, input int rs);
        si = 1'b0; start = 1'b1; abort = (ab == -1);
        @(posedge clk); #1;
        for (int t = 0; t < NCYC; t++) begin
            start = (t == rs); abort = (t == ab); si = bits[t];
            @(negedge clk);
            obs0[t] = obs_t'({bus0.s2p_en, bus0.word_valid, bus0.word_out, bus0.word_idx,
                              bus0.frame_sof, bus0.frame_eof, bus0.done, err0, busy0});
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; si = 1'b0;
    endtask

    task automatic compare0(input string nm);
        for (int t = 0; t < NCYC; t++) check(nm, t, 32'(mask(obs0[t])), 32'(mask(exp0[t])));
    endtask

    initial begin
        vec_t vecs [6];
        logic [NCYC-1:0] b;
        logic [11:0] got;
        int fw, errc, nwv, ab, rs;
        int wv1 [6];
        logic [3:0] wo1 [6];

        checks = 0; failures = 0; ptr = 0; stim = '0;
        vecs[0] = '{pre: 16'b001011,  plen: 6,  data: 12'h96F, exp_j: 5};
        vecs[1] = '{pre: 16'b1011,    plen: 4,  data: 12'hA53, exp_j: 3};
        vecs[2] = '{pre: 16'b1101011, plen: 7,  data: 12'h000, exp_j: 6};
        vecs[3] = '{pre: 16'b0111011, plen: 7,  data: 12'hFFF, exp_j: 6};
        vecs[4] = '{pre: 16'b01011,   plen: 5,  data: 12'h5A1, exp_j: 4};
        vecs[5] = '{pre: 16'h0000,    plen: 16, data: 12'h000, exp_j: -1};

        rst = 1'b1; start = 1'b0; start1 = 1'b0; abort = 1'b0; si = 1'b0; mute = 1'b0;
        #2;
        check("rst_state0", -1, 32'({bus0.s2p_en, bus0.word_valid, bus0.word_out, bus0.word_idx,
              bus0.frame_sof, bus0.frame_eof, bus0.done, err0, busy0}), 32'd0);
        check("rst_state1", -1, 32'({bus1.s2p_en, bus1.word_valid, bus1.word_out, bus1.word_idx,
              bus1.frame_sof, bus1.frame_eof, bus1.done, err1, busy1}), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Table vectors: sync position, word contents and timeout boundary.
        for (int i = 0; i < 6; i++) begin
            stim = '0; ptr = 0;
            push(vecs[i].pre, vecs[i].plen);
            push({4'h0, vecs[i].data}, 12);
            build_exp(stim, NONE);
            run0(stim, NONE, NONE);
            compare0("tbl_cycle");
            fw = -1; got = 12'h000; errc = -1;
            for (int t = 0; t < NCYC; t++) begin
                if (obs0[t].wv) begin
                    if (fw < 0) fw = t;
                    got = {got[7:0], obs0[t].wo};
                end
                if (obs0[t].err && errc < 0) errc = t;
            end
            check("tbl_first_word", i, fw, (vecs[i].exp_j < 0) ? -1 : vecs[i].exp_j + 6);
            check("tbl_words", i, 32'(got), 32'((vecs[i].exp_j < 0) ? 12'h000 : vecs[i].data));
            check("tbl_err_cycle", i, errc, (vecs[i].exp_j < 0) ? HT : -1);
        end

        // Abort right after word idx0, then a full frame with a stray start during LOAD.
        stim = '0; ptr = 0; push(16'b001011, 6); push(16'h096F, 12);
        build_exp(stim, 12);
        run0(stim, 12, NONE);
        compare0("abort_cycle");
        check("abort_en_drop", 13, 32'(obs0[13].en), 32'd0);
        nwv = 0;
        for (int t = 0; t < NCYC; t++) nwv += int'(obs0[t].done) + int'(obs0[t].eof);
        check("abort_no_done", 0, nwv, 0);
        build_exp(stim, NONE);
        run0(stim, NONE, 8);
        compare0("restart_cycle");

        // start and abort together in IDLE: nothing happens.
        build_exp(stim, -1);
        run0(stim, -1, NONE);
        compare0("start_abort_cycle");
        check("start_abort_busy", 0, 32'(obs0[0].busy), 32'd0);

        // s2p never strobes valid: LOAD watchdog fires after WIDTH+2 cycles.
        mute = 1'b1;
        run0(stim, NONE, NONE);
        mute = 1'b0;
        check("wd_en_before", 11, 32'(obs0[11].en), 32'd1);
        check("wd_err", 12, 32'({obs0[12].err, obs0[12].busy, obs0[12].en}), 32'b100);
        nwv = 0;
        for (int t = 0; t < NCYC; t++) nwv += int'(obs0[t].wv);
        check("wd_no_words", 0, nwv, 0);

        // Random streams with occasional abort and ignored restarts.
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < NCYC; k++) b[k] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                for (int k = 0; k < HT; k++) b[k] = 1'b0;
            end
            ab = NONE;
            if ($urandom_range(0, 2) == 0) ab = int'($urandom_range(0, 60));
            rs = NONE;
            if ($urandom_range(0, 2) == 0) rs = int'($urandom_range(0, (ab >= 0 && ab < 19) ? ab : 19));
            build_exp(b, ab);
            run0(b, ab, rs);
            compare0("rand_cycle");
        end

        // CONTINUOUS instance: SYNC inside GAP ignored, second frame after GAP, then rst mid-LOAD.
        stim = '0; ptr = 0;
        push(16'b001011, 6); push(16'h096F, 12); push(16'b0, 1); push(16'b1011, 4);
        push(16'b1011, 4); push(16'h0A5C, 12); push(16'b0, 5); push(16'b1011, 4); push(16'h0FFF, 12);
        wv1 = '{11, 15, 19, 32, 36, 40};
        wo1 = '{4'h9, 4'h6, 4'hF, 4'hA, 4'h5, 4'hC};
        si = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int t = 0; t < 52; t++) begin
            si = stim[t];
            @(negedge clk);
            obs1[t] = obs_t'({bus1.s2p_en, bus1.word_valid, bus1.word_out, bus1.word_idx,
                              bus1.frame_sof, bus1.frame_eof, bus1.done, err1, busy1});
            @(posedge clk); #1;
        end
        for (int t = 0; t < 52; t++) begin
            nwv = -1;
            for (int k = 0; k < 6; k++) if (wv1[k] == t) nwv = k;
            check("cont_valid", t, 32'({obs1[t].wv, obs1[t].err}), (nwv >= 0) ? 32'b10 : 32'b00);
            if (nwv >= 0) begin
                check("cont_word", t, 32'({obs1[t].wo, obs1[t].idx, obs1[t].done}),
                      32'({wo1[nwv], 2'(nwv % 3), (nwv % 3) == 2}));
            end
        end
        check("cont_gap_en", 20, 32'({obs1[19].en, obs1[20].en, obs1[22].en, obs1[23].busy}), 32'b0001);
        check("cont_load3_en", 51, 32'(obs1[51].en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_load", 52, 32'({bus1.s2p_en, bus1.word_valid, bus1.word_out, bus1.word_idx,
              bus1.frame_sof, bus1.frame_eof, bus1.done, err1, busy1}), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
